// File: rtl/if_fetch_queue_if.sv
// Bus bundles for the fetch queue.
// One for the instruction-memory port and one for the decode port.
interface if_fetch_queue_imem_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata
    );
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata
    );
endinterface

interface if_fetch_queue_id_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc
    );
    modport slave (
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: PC, fixed-latency imem requests,
// DEPTH-entry instruction queue toward decode, redirect flush.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    if_fetch_queue_imem_if.master      imem,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    if_fetch_queue_id_if.master        id,
    output logic [$clog2(DEPTH+1)-1:0] fq_level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW:0] DEPTH_C = (LW + 1)'(DEPTH);

    typedef enum logic {RUN, REDIR} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [LW-1:0]   count;
    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic            fetch_en;
    logic            req;
    logic            push;
    logic            pop;
    logic [LW:0]     credit;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // REDIR only marks the cycle after a flush; it fetches like RUN.
    always_comb begin
        fetch_en = 1'b0;
        unique case (state)
            RUN:   fetch_en = 1'b1;
            REDIR: fetch_en = 1'b1;
        endcase
    end

    // An in-flight response already holds a reserved slot.
    assign credit = {1'b0, count} + {{LW{1'b0}}, inflight};
    assign req    = !rst && fetch_en && !redirect_valid &&
                    (credit < DEPTH_C);
    assign push   = inflight && !redirect_valid;
    assign pop    = (count != '0) && id.id_ready;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign id.id_valid    = (count != '0);
    assign id.id_instr    = (count != '0) ? q_instr[rd_ptr] : '0;
    assign id.id_pc       = (count != '0) ? q_pc[rd_ptr] : '0;
    assign fq_level       = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            state    <= REDIR;
            pc       <= redirect_pc & ~XLEN'(3);
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= RUN;
            inflight <= req;
            if (req) begin
                inflight_pc <= pc;
                pc          <= pc + XLEN'(4);
            end
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                count <= count + LW'(1);
            else if (pop && !push)
                count <= count - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem.imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: scoreboarded fetch streams on a DEPTH=4
// instance and a DEPTH=2 instance whose PC wraps past the top.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        rv2 = 1'b0;
    logic [31:0] rp2 = '0;
    logic [2:0]  fq_level;
    logic [1:0]  fq_level2;

    int errors = 0;
    int checks = 0;
    int pops2  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb2[$];
    logic [31:0] req_log2[$];
    logic [31:0] mpc  = 32'h100;
    logic [31:0] mpc2 = 32'hFFFF_FFF8;

    if_fetch_queue_imem_if #(.XLEN(32)) im  ();
    if_fetch_queue_id_if   #(.XLEN(32)) id  ();
    if_fetch_queue_imem_if #(.XLEN(32)) im2 ();
    if_fetch_queue_id_if   #(.XLEN(32)) id2 ();

    if_fetch_queue #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .rst(rst), .imem(im),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id(id), .fq_level(fq_level)
    );

    if_fetch_queue #(
        .XLEN(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)
    ) dut2 (
        .clk(clk), .rst(rst), .imem(im2),
        .redirect_valid(rv2),
        .redirect_pc(rp2),
        .id(id2), .fq_level(fq_level2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        im.imem_rdata  <= im.imem_req ?
                          mem_word(im.imem_addr) : 32'hDEAD_BEEF;
        im2.imem_rdata <= im2.imem_req ?
                          mem_word(im2.imem_addr) : 32'hDEAD_BEEF;
    end

    always @(posedge rst) begin
        sb.delete();
        sb2.delete();
        req_log2.delete();
        mpc  = 32'h100;
        mpc2 = 32'hFFFF_FFF8;
    end

    // Scoreboard for the DEPTH=4 instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (redirect_valid) begin
                checks++;
                if (im.imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_req: got %b want 0", im.imem_req);
                end
                sb.delete();
                mpc = redirect_pc & ~32'd3;
            end else begin
                if (id.id_valid && id.id_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_pop: got pc %h want none", id.id_pc);
                    end else begin
                        e = sb.pop_front();
                        if (id.id_pc !== e.pc || id.id_instr !== e.instr) begin
                            errors++;
                            $display("FAIL sb_data: got %h/%h want %h/%h",
                                     id.id_pc, id.id_instr, e.pc, e.instr);
                        end
                    end
                end
                if (im.imem_req) begin
                    checks++;
                    if (im.imem_addr !== mpc) begin
                        errors++;
                        $display("FAIL req_addr: got %h want %h",
                                 im.imem_addr, mpc);
                    end
                    sb.push_back('{pc: mpc, instr: mem_word(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    // Scoreboard for the DEPTH=2 instance (decode always ready)
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (id2.id_valid) begin
                checks++;
                pops2++;
                if (sb2.size() == 0) begin
                    errors++;
                    $display("FAIL sb2_pop: got pc %h want none", id2.id_pc);
                end else begin
                    e = sb2.pop_front();
                    if (id2.id_pc !== e.pc || id2.id_instr !== e.instr) begin
                        errors++;
                        $display("FAIL sb2_data: got %h/%h want %h/%h",
                                 id2.id_pc, id2.id_instr, e.pc, e.instr);
                    end
                end
            end
            if (im2.imem_req) begin
                checks++;
                if (im2.imem_addr !== mpc2) begin
                    errors++;
                    $display("FAIL req2_addr: got %h want %h",
                             im2.imem_addr, mpc2);
                end
                req_log2.push_back(im2.imem_addr);
                sb2.push_back('{pc: mpc2, instr: mem_word(mpc2)});
                mpc2 = mpc2 + 32'd4;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns at the start of cycle 0 (first cycle with rst low)
    task automatic apply_reset();
        next_cycle();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        checks += 7;
        if (im.imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req: got %b want 0", im.imem_req);
        end
        if (id.id_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b want 0", id.id_valid);
        end
        if (fq_level !== 3'd0) begin
            errors++; $display("FAIL rst_level: got %0d want 0", fq_level);
        end
        if (id.id_instr !== 32'h0) begin
            errors++; $display("FAIL rst_instr: got %h want 0", id.id_instr);
        end
        if (id.id_pc !== 32'h0) begin
            errors++; $display("FAIL rst_pc: got %h want 0", id.id_pc);
        end
        if (im2.imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req2: got %b want 0", im2.imem_req);
        end
        if (id2.id_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid2: got %b want 0", id2.id_valid);
        end
    endtask

    task automatic test_startup();
        id.id_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        checks += 3;
        if (im.imem_req !== 1'b1 || im.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL start_req: got %b/%h want 1/100",
                     im.imem_req, im.imem_addr);
        end
        if (id.id_valid !== 1'b0) begin
            errors++; $display("FAIL start_c0_valid: got %b want 0", id.id_valid);
        end
        next_cycle();
        @(negedge clk);
        if (id.id_valid !== 1'b0) begin
            errors++; $display("FAIL start_c1_valid: got %b want 0", id.id_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (id.id_valid !== 1'b1 || id.id_pc !== 32'h100 ||
            id.id_instr !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL start_c2_head: got %b/%h/%h want 1/100/%h",
                     id.id_valid, id.id_pc, id.id_instr, mem_word(32'h100));
        end
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (id.id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_valid[%0d]: got %b want 1", i, id.id_valid);
            end
        end
    endtask

    task automatic test_stall();
        int nreq = 0;
        id.id_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (im.imem_req) nreq++;
            next_cycle();
        end
        @(negedge clk);
        checks += 3;
        if (nreq != 4) begin
            errors++; $display("FAIL stall_nreq: got %0d want 4", nreq);
        end
        if (fq_level !== 3'd4) begin
            errors++; $display("FAIL stall_level: got %0d want 4", fq_level);
        end
        if (im.imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_req: got %b want 0", im.imem_req);
        end
        next_cycle();
        id.id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (id.id_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_valid[%0d]: got %b want 1", i, id.id_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect();
        id.id_ready = 1'b0;
        apply_reset();
        repeat (4) begin
            @(negedge clk);
            next_cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h2002;
        @(negedge clk);
        checks++;
        if (fq_level !== 3'd3) begin
            errors++; $display("FAIL redir_pre_level: got %0d want 3", fq_level);
        end
        next_cycle();
        redirect_valid = 1'b0;
        id.id_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (fq_level !== 3'd0 || id.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: got %0d/%b want 0/0",
                     fq_level, id.id_valid);
        end
        if (im.imem_req !== 1'b1 || im.imem_addr !== 32'h2000) begin
            errors++;
            $display("FAIL redir_n1_req: got %b/%h want 1/2000",
                     im.imem_req, im.imem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (id.id_valid !== 1'b0) begin
            errors++; $display("FAIL redir_n2_valid: got %b want 0", id.id_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (id.id_valid !== 1'b1 || id.id_pc !== 32'h2000) begin
            errors++;
            $display("FAIL redir_n3_head: got %b/%h want 1/2000",
                     id.id_valid, id.id_pc);
        end
        repeat (6) next_cycle();
    endtask

    task automatic test_back_to_back();
        id.id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        next_cycle();
        redirect_pc = 32'h800;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (im.imem_req !== 1'b1 || im.imem_addr !== 32'h800) begin
            errors++;
            $display("FAIL b2b_req: got %b/%h want 1/800",
                     im.imem_req, im.imem_addr);
        end
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (id.id_valid && id.id_pc < 32'h800) begin
                errors++;
                $display("FAIL b2b_stale[%0d]: got pc %h want >= 800", i, id.id_pc);
            end
            if (i == 1) begin
                checks++;
                if (id.id_valid !== 1'b1 || id.id_pc !== 32'h800) begin
                    errors++;
                    $display("FAIL b2b_head: got %b/%h want 1/800",
                             id.id_valid, id.id_pc);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        id.id_ready = 1'b0;
        apply_reset();
        repeat (3) begin
            @(negedge clk);
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (fq_level !== 3'd2) begin
            errors++; $display("FAIL mid_pre_level: got %0d want 2", fq_level);
        end
        #1 rst = 1'b1;
        #1;
        checks += 2;
        if (id.id_valid !== 1'b0 || fq_level !== 3'd0) begin
            errors++;
            $display("FAIL mid_async: got %b/%0d want 0/0", id.id_valid, fq_level);
        end
        if (im.imem_req !== 1'b0) begin
            errors++; $display("FAIL mid_req: got %b want 0", im.imem_req);
        end
        next_cycle();
        rst = 1'b0;
        id.id_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (im.imem_req !== 1'b1 || im.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL mid_restart: got %b/%h want 1/100",
                     im.imem_req, im.imem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (fq_level !== 3'd0) begin
            errors++; $display("FAIL mid_c1_level: got %0d want 0", fq_level);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (id.id_valid !== 1'b1 || id.id_pc !== 32'h100) begin
            errors++;
            $display("FAIL mid_c2_head: got %b/%h want 1/100",
                     id.id_valid, id.id_pc);
        end
        repeat (4) next_cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        apply_reset();
        pops2 = 0;
        repeat (12) next_cycle();
        checks++;
        if (req_log2.size() < 3) begin
            errors++;
            $display("FAIL wrap_nreq: got %0d want >= 3", req_log2.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (req_log2[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d]: got %h want %h",
                             i, req_log2[i], want[i]);
                end
            end
        end
        checks++;
        if (pops2 < 5) begin
            errors++; $display("FAIL wrap_pops: got %0d want >= 5", pops2);
        end
    endtask

    initial begin
        id.id_ready  = 1'b0;
        id2.id_ready = 1'b1;
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
